npu_seq: RTL and testbench
==========================

# npu_seq

Run sequencer for the 3x3 weight-stationary systolic array. On a start command it reads N activation rows from the input buffer and feeds them into the array's three left lanes with diagonal skew. It holds array enable for the run, collects the three column sums from the array's bottom edge and de-skews them. It writes one packed 48-bit result word per input row to the result buffer. It sits between the Wishbone register block (command/status) and the PE array plus its two buffers.

## Interface
- AWIDTH, 8, buffer address width; all addresses wrap modulo 2^AWIDTH.
- ARRAY_ROWS, 3, PE rows; fixes the pipeline depth. Only 3 is supported.

Ports:
- wb_clk_i  in  1  sole clock; array and buffers share it.
- wb_rst_i  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse; sampled only in IDLE.
- abort  in  1  return to IDLE at the next edge; no done pulse.
- n_rows  in  8  row count N, latched on start.
- in_base  in  AWIDTH  first input-buffer address, latched on start.
- res_base  in  AWIDTH  first result-buffer address, latched on start.
- busy  out  1  high in PRIME and RUN.
- done  out  1  one-cycle pulse at the end of a run.
- in_rd  out  1  input-buffer read strobe.
- in_addr  out  AWIDTH  read address.
- in_data  in  24  row data, valid the cycle after in_rd. Byte k is lane k.
- arr_clr  out  1  one-cycle clear of the PE partial-sum and pass-through registers.
- arr_en  out  1  array enable.
- arr_in0, arr_in1, arr_in2  out  8 each  left-edge activations.
- arr_o0, arr_o1, arr_o2  in  16 each  bottom-edge column sums.
- res_we  out  1  result write strobe.
- res_addr  out  AWIDTH  result address.
- res_data  out  48  packed sums {col2, col1, col0}.

## Operation
- States: IDLE, PRIME, RUN.
- IDLE:
  - If start=1 and N=0: done pulses the next cycle. No reads or writes occur, and the state stays IDLE.
  - If start=1 and N>0: latch N, in_base and res_base, then go to PRIME.
- PRIME (1 cycle):
  - Assert arr_clr.
  - Assert in_rd with in_addr=in_base (row 0).
  - Clear counter t to 0, then go to RUN.
- RUN:
  - arr_en=1 every cycle.
  - t counts 0..N+4 (9-bit counter).
  - in_rd=1 with in_addr=in_base+t+1 while t<N-1.
- Feed skew, with feed cycle 0 being the first RUN cycle:
  - Row r byte k appears on arr_in_k at cycle r+k.
  - Lane 0 is in_data gated by the read-valid bit.
  - Lanes 1 and 2 pass through 1 and 2 skew registers respectively.
  - Any lane carrying no valid row drives 0, including cycles past the last row.
- Array model: every PE registers its right and down outputs. The sum for row r column j is therefore valid on arr_o_j at t=r+j+3.
- De-skew:
  - Hold col0 for 2 cycles and col1 for 1 cycle.
  - At t=r+5 (r=0..N-1), drive res_we=1, res_addr=res_base+r, res_data={arr_o2, col1_d1, col0_d2}.
  - A write-valid shift chain that tracks the feed validity generates res_we. Write count is exactly N.
- End of run: at t=N+4, after the final write, go to IDLE. done pulses on the following cycle while busy=0.
- Sums pass through unmodified: 16-bit per column, no saturation, no sign handling.
- abort: takes priority over all other activity and returns to IDLE at the next edge. It zeroes arr_en, in_rd, res_we and the skew/valid registers. done stays 0.
- start while busy: ignored. Latched fields do not change.

## Timing
- Reset (asynchronous): state=IDLE. busy, done, in_rd, arr_clr, arr_en and res_we are 0. in_addr, res_addr, res_data and arr_in0..2 are 0. Skew and valid registers are cleared.
- start-to-busy: 1 cycle.
- start-to-first-write: 7 cycles (PRIME + t=0..5).
- Run length: N+5 RUN cycles. busy is high for N+6 cycles. done occurs N+7 cycles after start.
- Throughput: one row per cycle. The next start is accepted the cycle done is high (state is IDLE).
- Address wrap: in_base+N-1 and res_base+N-1 wrap modulo 2^AWIDTH without error.

## Test plan
- Identity weights, N=1, row {3,2,1} at in_base=0x10 -> exactly one write at res_base, res_data={16'd1,16'd2,16'd3}, 7 cycles after start; done 1 cycle after that.
- All weights 0xFF, N=4, rows of 0xFF bytes -> 4 consecutive writes, each column 3*0xFF*0xFF=0x2FA03. Check 16-bit truncation matches the PE spec (0xFA03). Lane skew is exactly 0/1/2 cycles.
- N=255, in_base=res_base=0xF0 -> addresses wrap past 0xFF to 0x00..0xEE. 255 writes; busy is high for 261 cycles.
- N=0 start -> done pulse next cycle; busy, in_rd and res_we never assert.
- start pulsed at t=2 of a running job, then abort at t=3 -> the second start is ignored. The cycle after abort, busy, arr_en, in_rd and res_we are all 0, and done never pulses.
- wb_rst_i asserted mid-RUN, between clock edges -> all outputs read 0 immediately. The next start runs a clean job with correct results: arr_clr pulses and the stale skew data is gone.

Source files
------------

// File: rtl/npu_seq.sv
// npu_seq: run sequencer for the 3x3 weight-stationary systolic array.
//
// On start it reads N rows from the input buffer, feeds them into the three
// left lanes of the array with a 0/1/2 cycle diagonal skew, holds array
// enable for the run, de-skews the three bottom-edge column sums and writes
// one packed 48-bit word per row to the result buffer.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   start, abort              command pulse / immediate return to IDLE
//   n_rows, in_base, res_base run parameters, latched on an accepted start
//   busy, done                status: busy in PRIME/RUN, done one-cycle pulse
//   in_rd, in_addr, in_data   input-buffer read port (data one cycle later)
//   arr_clr, arr_en           array clear / enable
//   arr_in0..2                left-edge activations, lane k = byte k of a row
//   arr_o0..2                 bottom-edge column sums
//   res_we, res_addr, res_data result-buffer write port, {col2, col1, col0}
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; N=0 start only pulses done
// PRIME | clear the array and issue the read of row 0
// RUN   | t = 0..N+4: stream rows in, drain sums, write results
module npu_seq #(
  parameter int AWIDTH     = 8,
  parameter int ARRAY_ROWS = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        n_rows,
  input  logic [AWIDTH-1:0] in_base,
  input  logic [AWIDTH-1:0] res_base,
  output logic              busy,
  output logic              done,
  output logic              in_rd,
  output logic [AWIDTH-1:0] in_addr,
  input  logic [23:0]       in_data,
  output logic              arr_clr,
  output logic              arr_en,
  output logic [7:0]        arr_in0,
  output logic [7:0]        arr_in1,
  output logic [7:0]        arr_in2,
  input  logic [15:0]       arr_o0,
  input  logic [15:0]       arr_o1,
  input  logic [15:0]       arr_o2,
  output logic              res_we,
  output logic [AWIDTH-1:0] res_addr,
  output logic [47:0]       res_data
);

  // Cycles from row r entering lane 0 (t=r) to its write slot (t=r+5):
  // array depth plus one cycle per registered column hop to column 2.
  localparam int DRAIN = ARRAY_ROWS + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [AWIDTH-1:0] in_base_q, in_base_d;
  logic [AWIDTH-1:0] res_base_q, res_base_d;
  logic [8:0]        t_q, t_d;
  logic              done_q, done_d;

  logic              rd_vld_q;
  logic [7:0]        lane1_q, lane2a_q, lane2b_q;
  logic [DRAIN-1:0]  wv_q;
  logic [15:0]       col0_d1_q, col0_d2_q, col1_d1_q;

  logic [8:0]        n_ext;
  logic [8:0]        t_next;
  logic [23:0]       row_gated;

  assign n_ext     = {1'b0, n_q};
  assign t_next    = t_q + 9'd1;
  // Data on in_data is only a row when the previous cycle issued a read.
  assign row_gated = rd_vld_q ? in_data : 24'd0;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    in_base_d  = in_base_q;
    res_base_d = res_base_q;
    t_d        = t_q;
    done_d     = 1'b0;
    in_rd      = 1'b0;
    in_addr    = '0;
    arr_clr    = 1'b0;
    arr_en     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (n_rows == 8'd0) begin
            done_d = 1'b1;
          end else begin
            n_d        = n_rows;
            in_base_d  = in_base;
            res_base_d = res_base;
            state_d    = PRIME;
          end
        end
      end
      PRIME: begin
        arr_clr = 1'b1;
        in_rd   = 1'b1;
        in_addr = in_base_q;
        t_d     = 9'd0;
        state_d = RUN;
      end
      RUN: begin
        arr_en = 1'b1;
        t_d    = t_next;
        // Row t+1 is fetched during cycle t so it lands on lane 0 at t+1.
        if (t_next < n_ext) begin
          in_rd   = 1'b1;
          in_addr = in_base_q + AWIDTH'(t_next);
        end
        if (t_q == n_ext + 9'(DRAIN - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      in_rd   = 1'b0;
      in_addr = '0;
      arr_clr = 1'b0;
      arr_en  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      n_q        <= 8'd0;
      in_base_q  <= '0;
      res_base_q <= '0;
      t_q        <= 9'd0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      lane1_q    <= 8'd0;
      lane2a_q   <= 8'd0;
      lane2b_q   <= 8'd0;
      wv_q       <= '0;
      col0_d1_q  <= 16'd0;
      col0_d2_q  <= 16'd0;
      col1_d1_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      in_base_q  <= in_base_d;
      res_base_q <= res_base_d;
      t_q        <= t_d;
      done_q     <= done_d;
      col0_d1_q  <= arr_o0;
      col0_d2_q  <= col0_d1_q;
      col1_d1_q  <= arr_o1;
      if (abort) begin
        rd_vld_q <= 1'b0;
        lane1_q  <= 8'd0;
        lane2a_q <= 8'd0;
        lane2b_q <= 8'd0;
        wv_q     <= '0;
      end else begin
        rd_vld_q <= in_rd;
        lane1_q  <= row_gated[15:8];
        lane2a_q <= row_gated[23:16];
        lane2b_q <= lane2a_q;
        // Write-valid follows lane-0 validity through the array latency.
        wv_q     <= {wv_q[DRAIN-2:0], rd_vld_q};
      end
    end
  end

  assign busy     = (state_q == PRIME) || (state_q == RUN);
  assign done     = done_q;
  assign arr_in0  = row_gated[7:0];
  assign arr_in1  = lane1_q;
  assign arr_in2  = lane2b_q;
  assign res_we   = wv_q[DRAIN-1] & ~abort;
  // t - DRAIN is the row index being written in this slot.
  assign res_addr = res_we ? (res_base_q + AWIDTH'(t_q - 9'(DRAIN))) : '0;
  assign res_data = res_we ? {arr_o2, col1_d1_q, col0_d2_q} : 48'd0;

endmodule

// File: tb/tb_npu_seq.sv
module tb_npu_seq;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start, abort;
  logic [7:0]  n_rows, in_base, res_base;
  logic        busy, done, in_rd, arr_clr, arr_en, res_we;
  logic [7:0]  in_addr, res_addr;
  logic [23:0] in_data;
  logic [7:0]  arr_in0, arr_in1, arr_in2;
  logic [15:0] arr_o0, arr_o1, arr_o2;
  logic [47:0] res_data;

  npu_seq #(.AWIDTH(8), .ARRAY_ROWS(3)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
    .n_rows(n_rows), .in_base(in_base), .res_base(res_base),
    .busy(busy), .done(done), .in_rd(in_rd), .in_addr(in_addr),
    .in_data(in_data), .arr_clr(arr_clr), .arr_en(arr_en),
    .arr_in0(arr_in0), .arr_in1(arr_in1), .arr_in2(arr_in2),
    .arr_o0(arr_o0), .arr_o1(arr_o1), .arr_o2(arr_o2),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Environment: input buffer, weights and a registered 3x3 PE array.
  logic [23:0] in_mem [256];
  logic [7:0]  w [3][3];
  logic [7:0]  pe_a [3][3];
  logic [15:0] pe_s [3][3];
  logic [7:0]  lane [3];
  assign lane[0] = arr_in0;
  assign lane[1] = arr_in1;
  assign lane[2] = arr_in2;
  assign arr_o0 = pe_s[2][0];
  assign arr_o1 = pe_s[2][1];
  assign arr_o2 = pe_s[2][2];

  always @(posedge wb_clk_i) begin
    in_data <= in_rd ? in_mem[in_addr] : 24'($urandom);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (arr_clr) begin
          pe_a[i][j] <= 8'd0;
          pe_s[i][j] <= 16'd0;
        end else if (arr_en) begin
          pe_a[i][j] <= (j == 0) ? lane[i] : pe_a[i][(j+2)%3];
          pe_s[i][j] <= ((i == 0) ? 16'd0 : pe_s[(i+2)%3][j]) +
                        16'((j == 0) ? lane[i] : pe_a[i][(j+2)%3]) * 16'(w[i][j]);
        end
      end
    end
  end

  // Scoreboard
  typedef struct { int cyc; logic [7:0] addr; logic [47:0] data; } wr_t;
  typedef struct { int cyc; int blen; } dn_t;
  wr_t exp_wr[$];
  dn_t exp_dn[$];
  int checks = 0;
  int passes = 0;
  int busy_run = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: each result column is the dot product of the row's bytes
  // with that weight column, kept to 16 bits.
  function automatic logic [47:0] exp_row(input logic [23:0] word);
    logic [47:0] r;
    r = '0;
    for (int j = 0; j < 3; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < 3; i++) s += int'(word[8*i +: 8]) * int'(w[i][j]);
      r[16*j +: 16] = s[15:0];
    end
    return r;
  endfunction

  // Monitor
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        busy_run = 0;
      end else begin
        if (abort) busy_run = 0;
        else if (busy) busy_run++;
        if (res_we) begin
          if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_cycle", cyc, e.cyc);
            chk("wr_addr", res_addr, e.addr);
            chk("wr_data", res_data, e.data);
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_dn.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            dn_t d;
            d = exp_dn.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("busy_length", busy_run, d.blen);
          end
          busy_run = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  task automatic fill_mem();
    for (int a = 0; a < 256; a++) in_mem[a] = 24'($urandom);
  endtask

  task automatic rand_w();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w[i][j] = 8'($urandom);
  endtask

  task automatic issue(input int n, input logic [7:0] ib, input logic [7:0] rb);
    int p;
    p = cyc;
    start = 1'b1; n_rows = 8'(n); in_base = ib; res_base = rb;
    if (n == 0) exp_dn.push_back('{p + 1, 0});
    else begin
      for (int r = 0; r < n; r++)
        exp_wr.push_back('{p + 7 + r, 8'(rb + r), exp_row(in_mem[8'(ib + r)])});
      exp_dn.push_back('{p + n + 7, n + 6});
    end
    tick();
    start = 1'b0;
    if (n == 0) begin
      chk("n0_busy", busy, 0);
      chk("n0_in_rd", in_rd, 0);
      chk("n0_done", done, 1);
    end else begin
      chk("prime_busy", busy, 1);
      chk("prime_clr", arr_clr, 1);
      chk("prime_rd", in_rd, 1);
      chk("prime_addr", in_addr, ib);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_dn.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    chk("run_completes", exp_dn.size() == 0, 1);
    if (exp_dn.size() != 0) begin
      exp_wr.delete();
      exp_dn.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_rd"}, in_rd, 0);
    chk({tag, "_arr_clr"}, arr_clr, 0);
    chk({tag, "_arr_en"}, arr_en, 0);
    chk({tag, "_res_we"}, res_we, 0);
    chk({tag, "_in_addr"}, in_addr, 0);
    chk({tag, "_res_addr"}, res_addr, 0);
    chk({tag, "_res_data"}, res_data, 0);
    chk({tag, "_arr_in0"}, arr_in0, 0);
    chk({tag, "_arr_in1"}, arr_in1, 0);
    chk({tag, "_arr_in2"}, arr_in2, 0);
  endtask

  initial begin
    int dc0;
    start = 0; abort = 0; n_rows = 0; in_base = 0; res_base = 0;
    wb_rst_i = 1'b1;
    fill_mem();
    rand_w();
    tick(); tick();
    check_all_zero("reset");
    wb_rst_i = 1'b0;
    tick();

    // Identity weights, single row
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w[i][j] = (i == j) ? 8'd1 : 8'd0;
    in_mem[8'h10] = 24'h010203;
    issue(1, 8'h10, 8'h20);
    wait_idle(40);

    // All 0xFF, with an ignored start at t=2
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w[i][j] = 8'hFF;
    for (int a = 8'h40; a < 8'h44; a++) in_mem[a] = 24'hFFFFFF;
    issue(4, 8'h40, 8'h80);
    tick(); tick(); tick();
    start = 1'b1; n_rows = 8'd9; in_base = 8'h00; res_base = 8'h00;
    tick();
    start = 1'b0;
    wait_idle(40);

    // N=0
    issue(0, 8'h33, 8'h44);
    wait_idle(10);
    repeat (5) tick();

    // Back-to-back: restart in the done cycle
    fill_mem(); rand_w();
    issue(3, 8'h05, 8'h60);
    begin
      int k;
      k = 0;
      while (!done && k < 50) begin tick(); k++; end
    end
    chk("b2b_done_seen", done, 1);
    issue(2, 8'hA0, 8'h70);
    wait_idle(40);

    // Long run with address wrap
    fill_mem(); rand_w();
    issue(255, 8'hF0, 8'hF0);
    wait_idle(400);

    // Ignored start at t=2 then abort at t=3
    fill_mem(); rand_w();
    dc0 = done_cnt;
    issue(6, 8'h20, 8'h30);
    tick(); tick(); tick();
    start = 1'b1; n_rows = 8'd2; in_base = 8'h00; res_base = 8'h00;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_wr.delete();
    exp_dn.delete();
    chk("abort_busy", busy, 0);
    chk("abort_arr_en", arr_en, 0);
    chk("abort_in_rd", in_rd, 0);
    chk("abort_res_we", res_we, 0);
    repeat (15) tick();
    chk("abort_no_done", done_cnt, dc0);

    // Reset asserted mid-run between edges, then a clean job
    fill_mem(); rand_w();
    issue(8, 8'h50, 8'h90);
    repeat (4) tick();
    wb_rst_i = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_wr.delete();
    exp_dn.delete();
    tick();
    wb_rst_i = 1'b0;
    tick();
    issue(5, 8'h51, 8'h91);
    wait_idle(40);

    // Randomized jobs
    for (int k = 0; k < 10; k++) begin
      int n;
      fill_mem(); rand_w();
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
      issue(n, 8'($urandom), 8'($urandom));
      wait_idle(60);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (5) tick();
    chk("queues_drained", exp_wr.size() + exp_dn.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
